// File: rtl/controller_poller.sv
// controller_poller: polls two NES-style gamepads in parallel over the
// latch / clock / serial-data protocol and commits both button bytes
// atomically at the end of each poll. The committed bytes are exposed to the
// CPU through a small combinational read port.
module controller_poller #(
  parameter int HALF_PERIOD = 76,
  parameter int NUM_BITS    = 8
) (
  input  logic       clk_12_5875,
  input  logic       rst,
  input  logic       start,
  input  logic       pad_data_0,
  input  logic       pad_data_1,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       read_select,
  input  logic       read_address,
  output logic [7:0] read_data,
  output logic [7:0] buttons_0,
  output logic [7:0] buttons_1,
  output logic       busy,
  output logic       poll_done
);

  localparam int CNT_W = (2 * HALF_PERIOD > 1) ? $clog2(2 * HALF_PERIOD) : 1;
  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);
  localparam logic [7:0]       BIT_MASK   = 8'((9'd1 << NUM_BITS) - 9'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LOW,
    S_CLK_HIGH,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_shift0;
  logic [7:0]       r_shift1;
  logic [7:0]       r_buttons0;
  logic [7:0]       r_buttons1;
  logic             r_padLatch;
  logic             r_padClk;
  logic             r_busy;
  logic             r_pollDone;
  logic             w_latchEnd;
  logic             w_halfEnd;
  logic             w_latchNext;
  logic             w_clkNext;
  logic             w_busyNext;
  logic             w_doneNext;

  assign w_latchEnd = (r_cnt == LATCH_LAST);
  assign w_halfEnd  = (r_cnt == HALF_LAST);

  // State register plus the registered pad/status outputs derived from the next state
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_padLatch <= 1'b0;
      r_padClk   <= 1'b1;
      r_busy     <= 1'b0;
      r_pollDone <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_padLatch <= w_latchNext;
      r_padClk   <= w_clkNext;
      r_busy     <= w_busyNext;
      r_pollDone <= w_doneNext;
    end
  end

  // Next-state logic: each phase ends when its cycle counter reaches the last cycle
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (start) w_nextState = S_LATCH;
      S_LATCH:    if (w_latchEnd) w_nextState = S_CLK_LOW;
      S_CLK_LOW:  if (w_halfEnd) w_nextState = S_CLK_HIGH;
      S_CLK_HIGH: begin
        if (w_halfEnd) begin
          w_nextState = (r_idx == IDX_LAST) ? S_DONE : S_CLK_LOW;
        end
      end
      S_DONE:     w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    w_latchNext = (w_nextState == S_LATCH);
    w_clkNext   = (w_nextState != S_CLK_LOW);
    w_busyNext  = (w_nextState != S_IDLE);
    w_doneNext  = (w_nextState == S_DONE);
  end

  // Phase cycle counter and bit index; both restart whenever the phase changes
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      if ((w_nextState != r_state) || (r_state == S_IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_LATCH) begin
        r_idx <= '0;
      end else if ((r_state == S_CLK_HIGH) && w_halfEnd && (r_idx != IDX_LAST)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Capture the inverted serial bits at the end of the low half, when the pad data has settled
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r_shift0 <= 8'h00;
      r_shift1 <= 8'h00;
    end else if (r_state == S_LATCH) begin
      r_shift0 <= 8'h00;
      r_shift1 <= 8'h00;
    end else if ((r_state == S_CLK_LOW) && w_halfEnd) begin
      r_shift0[r_idx] <= ~pad_data_0;
      r_shift1[r_idx] <= ~pad_data_1;
    end
  end

  // Commit both bytes together on the edge into DONE so readers never see a mix
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r_buttons0 <= 8'h00;
      r_buttons1 <= 8'h00;
    end else if ((w_nextState == S_DONE) && (r_state != S_DONE)) begin
      r_buttons0 <= r_shift0 & BIT_MASK;
      r_buttons1 <= r_shift1 & BIT_MASK;
    end
  end

  // CPU read port: selected committed byte, zero when the window is not addressed
  always_comb begin
    read_data = 8'h00;
    if (read_select) begin
      read_data = read_address ? r_buttons1 : r_buttons0;
    end
  end

  assign pad_latch = r_padLatch;
  assign pad_clk   = r_padClk;
  assign busy      = r_busy;
  assign poll_done = r_pollDone;
  assign buttons_0 = r_buttons0;
  assign buttons_1 = r_buttons1;

endmodule
